// File: rtl/debounce_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | debounce_pkg: shared types and helpers for input_debounce             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } db_state_t;

    // Counter width for a given stability threshold, never narrower than 1 bit.
    function automatic int db_cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sync_chain: SYNC_STAGES-deep flop synchroniser, async active-low reset |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | input_debounce: synchronise + filter a raw input; edge pulses when    |
// | DEBOUNCE_EDGE_EN is defined, otherwise rise/fall are tied low.         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module input_debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W      = db_cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic             w_s;
    db_state_t        r_state;
    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_dout;
    logic             w_dout_nxt;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (din),
        .o_q   (w_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LO;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    // An opposing sample always wins over reaching the threshold.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = r_dout;
        case (r_state)
            ST_LO: begin
                w_cnt_nxt = '0;
                if (w_s) begin
                    w_state_nxt = CHK_HI;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            CHK_HI: begin
                if (!w_s) begin
                    w_state_nxt = ST_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_HI;
                    w_cnt_nxt   = '0;
                    w_dout_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            ST_HI: begin
                w_cnt_nxt = '0;
                if (!w_s) begin
                    w_state_nxt = CHK_LO;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            CHK_LO: begin
                if (w_s) begin
                    w_state_nxt = ST_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_LO;
                    w_cnt_nxt   = '0;
                    w_dout_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = ST_LO;
                w_cnt_nxt   = '0;
                w_dout_nxt  = 1'b0;
            end
        endcase
    end

    assign dout = r_dout;

`ifdef DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // dout only moves on an acceptance, so its change is the edge event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_dout_nxt & ~r_dout;
            r_fall <= ~w_dout_nxt & r_dout;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_input_debounce: table vectors, corner sequences, random vs model   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_input_debounce;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic din   = 1'b0;
    logic dout;
    logic rise;
    logic fall;

    int n_total = 0;
    int n_pass  = 0;

    input_debounce #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .dout  (dout),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    // Reference: s is din delayed by SYNC edges; dout flips once the last
    // STABLE samples of s all disagree with it.
    bit m_dout, m_rise, m_fall;
    bit dq[$];
    bit win[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq = {};
            for (int i = 0; i < SYNC; i++) dq.push_back(1'b0);
            win = {};
            m_dout = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
        end else begin
            bit s;
            int diff;
            s = dq.pop_front();
            dq.push_back(din);
            win.push_back(s);
            if (win.size() > STABLE) void'(win.pop_front());
            m_rise = 1'b0;
            m_fall = 1'b0;
            diff = 0;
            foreach (win[i]) if (win[i] != m_dout) diff++;
            if (diff == STABLE) begin
                m_dout = ~m_dout;
                m_rise = EDGE & m_dout;
                m_fall = EDGE & ~m_dout;
            end
        end
    end

    typedef struct {
        string name;
        logic  d;
        logic  exp_dout;
        logic  exp_rise;
        logic  exp_fall;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(string n, logic d, logic o, logic r, logic f);
        vec_t v;
        v.name     = n;
        v.d        = d;
        v.exp_dout = o;
        v.exp_rise = r & EDGE;
        v.exp_fall = f & EDGE;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk3(input string name, input logic o, input logic r, input logic f);
        chk({name, " dout"}, dout, o);
        chk({name, " rise"}, rise, r & EDGE);
        chk({name, " fall"}, fall, f & EDGE);
    endtask

    task automatic step(input logic d);
        @(negedge clk);
        din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

        // Reset held with din toggling: outputs stay low.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            din = ~din;
            @(posedge clk);
            #1;
            chk3("in_reset", 1'b0, 1'b0, 1'b0);
        end
        // Release with din high: normal detection.
        @(negedge clk);
        din   = 1'b1;
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            chk3("post_reset", e >= 6, e == 6, 1'b0);
        end
        for (int i = 0; i < 10; i++) step(1'b0);

        for (int k = 1; k <= 10; k++) add("step", 1'b1, k >= 6, k == 6, 1'b0);
        for (int k = 1; k <= 8;  k++) add("fall", 1'b0, k < 6, 1'b0, k == 6);
        for (int k = 1; k <= 3;  k++) add("glitch3", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 6;  k++) add("glitch3", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4;  k++) add("glitch4", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 5; k <= 14; k++) add("glitch4", 1'b0, (k >= 6) && (k <= 9), k == 6, k == 10);

        foreach (tbl[i]) begin
            step(tbl[i].d);
            chk({tbl[i].name, " dout"}, dout, tbl[i].exp_dout);
            chk({tbl[i].name, " rise"}, rise, tbl[i].exp_rise);
            chk({tbl[i].name, " fall"}, fall, tbl[i].exp_fall);
        end

        // Bounce: accept 6 edges after the final run of ones starts (index 5).
        for (int k = 0; k < 16; k++) begin
            step((k < 9) ? pat[k] : 1'b1);
            chk3("bounce", k >= 10, k == 10, 1'b0);
        end

        // Async reset during a falling check drops dout without a clock.
        for (int e = 1; e <= 4; e++) step(1'b0);
        chk3("fall_midchk", 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk3("async_rst", 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step(1'b0);
            chk3("after_rst_lo", 1'b0, 1'b0, 1'b0);
        end

        // Async reset during a rising check: no pulse, counting restarts.
        for (int e = 1; e <= 4; e++) step(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk3("rise_abort", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk3("rise_abort_hold", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            chk3("restart", e >= 6, e == 6, 1'b0);
        end

        // Random stimulus against the reference model.
        for (int i = 0; i < 1500; i++) begin
            logic d;
            d = ($urandom_range(0, 3) == 0) ? ~din : din;
            if ($urandom_range(0, 40) == 0) begin
                for (int j = 0; j < 6; j++) begin
                    step(d);
                    chk("rnd dout", dout, m_dout);
                    chk("rnd rise", rise, m_rise);
                    chk("rnd fall", fall, m_fall);
                end
            end else begin
                step(d);
                chk("rnd dout", dout, m_dout);
                chk("rnd rise", rise, m_rise);
                chk("rnd fall", fall, m_fall);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
